g_sbox_sched: RTL and testbench
===============================

G_SBOX_SCHED -- requirements
Module: g_sbox_sched

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset; asserting it clears all state immediately, release is synchronous to clk.
REQ-003 req_a  input  1  key-schedule requester wants one 32-bit G-function substitution; held with word_a until gnt_a.
REQ-004 word_a  input  32  key-schedule operand, byte 0 = bits [7:0].
REQ-005 req_b  input  1  round-datapath requester; same rules as req_a.
REQ-006 word_b  input  32  round-datapath operand.
REQ-007 gnt_a, gnt_b  output  1 each  combinational accept strobes; operand is captured on the edge ending a cycle where gnt is high.
REQ-008 sb_in  output  8  byte presented to the shared 8-bit S-box unit.
REQ-009 sb_sel  output  1  S-box select: 0 = S1, 1 = S2.
REQ-010 sb_res  input  8  combinational S-box result for sb_in/sb_sel, valid in the same cycle.
REQ-011 busy  output  1  high while a substitution is in progress (states SUB and DONE).
REQ-012 res_valid  output  1  one-cycle result strobe.
REQ-013 res_id  output  1  owner of res_word: 0 = A, 1 = B.
REQ-014 res_word  output  32  substituted word; valid only while res_valid is high.

Function
REQ-015 The FSM SHALL have 3 states: IDLE, SUB (2-bit byte counter cnt), DONE.
REQ-016 Grants SHALL be issued only in IDLE or DONE, at most one per cycle; gnt_x SHALL be 0 in SUB.
REQ-017 Arbitration SHALL be round-robin. A lone requester is granted. When both request, the requester not granted last is granted. After reset, A has priority.
REQ-018 On the grant edge the block SHALL latch the operand and owner, set cnt=0 and enter SUB.
REQ-019 In SUB, sb_in SHALL equal operand byte cnt and sb_sel SHALL equal cnt[0] (even bytes use S1, odd bytes use S2).
REQ-020 On each SUB edge, sb_res SHALL be written to res_word byte cnt and cnt SHALL increment; at cnt=3 the FSM SHALL enter DONE.
REQ-021 In DONE, res_valid SHALL be 1 for exactly one cycle with res_word and res_id stable.
REQ-022 DONE SHALL go to SUB if a grant is issued in that cycle, otherwise to IDLE. This gives back-to-back throughput of one word per 5 cycles.
REQ-023 Latency: grant in cycle G, bytes processed in G+1..G+4, res_valid in G+5.
REQ-024 Outside SUB, sb_in SHALL be 0x00 and sb_sel SHALL be 0.
REQ-025 res_word SHALL hold its last value when res_valid is 0; its content is unspecified to consumers.
REQ-026 Request changes during SUB SHALL be ignored. Requests are sampled only in IDLE or DONE.
REQ-027 Dropping a request before its grant SHALL be legal; no grant is owed and the round-robin pointer is unchanged.

Reset
REQ-028 During reset the FSM SHALL be in IDLE with cnt=0 and the priority pointer favouring A.
REQ-029 During reset gnt_a, gnt_b, busy, res_valid, res_id, sb_sel SHALL be 0, and res_word and sb_in SHALL be 0x00 / 0x00000000.
REQ-030 Reset asserted during SUB or DONE SHALL discard the operation, with no res_valid after release.
REQ-031 The first grant after reset release SHALL occur no earlier than the first rising edge with rst_n high.

Verification
REQ-032 req_a=1, word_a=0x00000000, bench S-box model -> gnt_a in cycle G, sb_sel sequence 0,1,0,1, res_valid in G+5, res_word=0x38A938A9, res_id=0.
REQ-033 req_a and req_b both high continuously from reset -> grants alternate A,B,A,B; res_valid every 5 cycles; res_id alternates 0,1,0,1.
REQ-034 word_b=0x03020100 -> sb_in sequence 0x00,0x01,0x02,0x03 in G+1..G+4, and each res_word byte matches the model.
REQ-035 rst_n pulled low in cycle G+2 of an operation -> all outputs are 0 immediately; after release, no res_valid until a new grant.
REQ-036 req_b is toggled during SUB and dropped before DONE -> no gnt_b; FSM returns to IDLE after DONE.
REQ-037 Lone req_b held with A idle -> gnt_b is issued every 5 cycles back-to-back, with busy continuously high.

Source files
------------

// File: rtl/g_sbox_sched.sv
// g_sbox_sched: two-requester round-robin scheduler that time-shares one
// 8-bit S-box across 32-bit G-function substitutions. Each accepted word
// takes four SUB cycles (one byte each) plus a DONE cycle for the result.
module g_sbox_sched (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_a,
   input  logic [31:0] word_a,
   input  logic        req_b,
   input  logic [31:0] word_b,
   output logic        gnt_a,
   output logic        gnt_b,
   output logic [7:0]  sb_in,
   output logic        sb_sel,
   input  logic [7:0]  sb_res,
   output logic        busy,
   output logic        res_valid,
   output logic        res_id,
   output logic [31:0] res_word
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SUB  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t      state_reg, state_next;
   logic [1:0]  cnt_reg, cnt_next;
   logic [31:0] op_word_reg;
   logic        res_id_reg;
   logic        prio_b_reg;   // 1: B wins the next tie (A was granted last)
   logic [7:0]  res_byte_reg [4];
   logic        grant_ok;
   logic        grant_any;

   // Arbitration: grants only when idle or finishing, never while reset is held.
   always_comb begin
      grant_ok  = rst_n && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
      gnt_a     = grant_ok && req_a && (!req_b || !prio_b_reg);
      gnt_b     = grant_ok && req_b && (!req_a ||  prio_b_reg);
      grant_any = gnt_a || gnt_b;
   end

   // State register plus operand/owner capture and round-robin pointer update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= ST_IDLE;
         cnt_reg     <= 2'd0;
         op_word_reg <= 32'h0000_0000;
         res_id_reg  <= 1'b0;
         prio_b_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (grant_any) begin
            op_word_reg <= gnt_a ? word_a : word_b;
            res_id_reg  <= gnt_b;
            prio_b_reg  <= gnt_a;
         end
      end
   end

   // One result byte register per lane; lane gi is written on the SUB edge with cnt == gi.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_res_byte
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               res_byte_reg[gi] <= 8'h00;
            end else if ((state_reg == ST_SUB) && (cnt_reg == 2'(gi))) begin
               res_byte_reg[gi] <= sb_res;
            end
         end
         assign res_word[gi*8 +: 8] = res_byte_reg[gi];
      end
   endgenerate

   // Next-state logic: IDLE/DONE -> SUB on a grant, SUB walks bytes 0..3 then DONE.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         ST_IDLE: begin
            if (grant_any) begin
               state_next = ST_SUB;
               cnt_next   = 2'd0;
            end
         end
         ST_SUB: begin
            cnt_next = cnt_reg + 2'd1;
            if (cnt_reg == 2'd3) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            cnt_next = 2'd0;
            state_next = grant_any ? ST_SUB : ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
            cnt_next   = 2'd0;
         end
      endcase
   end

   // Outputs: S-box drive only in SUB (even bytes S1, odd bytes S2), result strobe in DONE.
   always_comb begin
      busy      = (state_reg == ST_SUB) || (state_reg == ST_DONE);
      res_valid = (state_reg == ST_DONE);
      res_id    = res_id_reg;
      sb_in     = 8'h00;
      sb_sel    = 1'b0;
      if (state_reg == ST_SUB) begin
         sb_in  = op_word_reg[cnt_reg*8 +: 8];
         sb_sel = cnt_reg[0];
      end
   end

endmodule

// File: tb/tb_g_sbox_sched.sv
// tb_g_sbox_sched: randomized scoreboard bench for g_sbox_sched with an
// arithmetic S-box stand-in and a cycle-level reference of the scheduler.
module tb_g_sbox_sched;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_a = 1'b0, req_b = 1'b0;
   logic [31:0] word_a = 32'h0, word_b = 32'h0;
   logic        gnt_a, gnt_b, sb_sel, busy, res_valid, res_id;
   logic [7:0]  sb_in, sb_res;
   logic [31:0] res_word;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      logic        id;
      logic [31:0] word;
      int          due;
   } exp_t;
   exp_t exp_q[$];

   // model state
   logic        active = 1'b0;
   int          cur_start = 0;
   logic [31:0] cur_word = 32'h0;
   logic        last_b = 1'b1;      // B granted last -> A wins ties (reset state)
   logic        last_gnt_a = 1'b0, last_gnt_b = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] sbox(input logic sel, input logic [7:0] x);
      if (sel) return 8'(x * 8'd13) ^ 8'h38;
      return 8'(x * 8'd7 + 8'hA9);
   endfunction

   function automatic logic [31:0] subst(input logic [31:0] w);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[i*8 +: 8] = sbox(1'(i % 2), w[i*8 +: 8]);
      return r;
   endfunction

   assign sb_res = sbox(sb_sel, sb_in);

   g_sbox_sched dut (
      .clk(clk), .rst_n(rst_n),
      .req_a(req_a), .word_a(word_a), .req_b(req_b), .word_b(word_b),
      .gnt_a(gnt_a), .gnt_b(gnt_b), .sb_in(sb_in), .sb_sel(sb_sel), .sb_res(sb_res),
      .busy(busy), .res_valid(res_valid), .res_id(res_id), .res_word(res_word)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_gnt"}, {30'd0, gnt_a, gnt_b}, 32'h0);
      check({tag, "_busy"}, {31'd0, busy}, 32'h0);
      check({tag, "_valid"}, {31'd0, res_valid}, 32'h0);
      check({tag, "_id"}, {31'd0, res_id}, 32'h0);
      check({tag, "_sbsel"}, {31'd0, sb_sel}, 32'h0);
      check({tag, "_sbin"}, {24'd0, sb_in}, 32'h0);
      check({tag, "_word"}, res_word, 32'h0);
   endtask

   // Reference: grants, busy and S-box drive predicted each cycle; results queued at grant.
   always @(negedge clk) begin
      int k;
      logic free, exp_ga, exp_gb, exp_busy, exp_sel;
      logic [7:0] exp_sbin;
      if (!rst_n) begin
         check_all_zero("rst");
         active = 1'b0;
         last_b = 1'b1;
         exp_q.delete();
         last_gnt_a = 1'b0;
         last_gnt_b = 1'b0;
      end else begin
         k = cyc - cur_start;
         free = !active || (k == 5);
         exp_ga = free && req_a && (!req_b || last_b);
         exp_gb = free && req_b && (!req_a || !last_b);
         check("gnt_a", {31'd0, gnt_a}, {31'd0, exp_ga});
         check("gnt_b", {31'd0, gnt_b}, {31'd0, exp_gb});
         exp_busy = active && k >= 1 && k <= 5;
         exp_sbin = 8'h00;
         exp_sel = 1'b0;
         if (active && k >= 1 && k <= 4) begin
            exp_sbin = cur_word[(k-1)*8 +: 8];
            exp_sel = 1'((k - 1) % 2);
         end
         check("busy", {31'd0, busy}, {31'd0, exp_busy});
         check("sb_in", {24'd0, sb_in}, {24'd0, exp_sbin});
         check("sb_sel", {31'd0, sb_sel}, {31'd0, exp_sel});
         if (active && k == 5) active = 1'b0;
         if (exp_ga || exp_gb) begin
            exp_t e;
            active = 1'b1;
            cur_start = cyc;
            cur_word = exp_ga ? word_a : word_b;
            last_b = exp_gb;
            e.id = exp_gb;
            e.word = subst(cur_word);
            e.due = cyc + 5;
            exp_q.push_back(e);
            $display("grant cyc=%0d id=%0d word=%h", cyc, exp_gb, cur_word);
         end
         last_gnt_a = gnt_a;
         last_gnt_b = gnt_b;
      end
   end

   // Monitor: pops an expectation whenever the DUT strobes a result.
   always @(negedge clk) begin
      if (rst_n) begin
         if (res_valid) begin
            if (exp_q.size() == 0) begin
               check("res_unexpected", {31'd0, res_valid}, 32'h0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("res_word", res_word, e.word);
               check("res_id", {31'd0, res_id}, {31'd0, e.id});
               check("res_cycle", cyc, e.due);
               $display("result cyc=%0d id=%0d word=%h", cyc, res_id, res_word);
            end
         end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            check("res_missing", {31'd0, res_valid}, 32'h1);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic got;
      // reset
      repeat (3) step();
      rst_n = 1'b1;

      // both requesters held from reset: A,B alternate; includes 0x0 and 0x03020100
      req_a = 1'b1; word_a = 32'h0000_0000;
      req_b = 1'b1; word_b = 32'h0302_0100;
      repeat (30) step();

      // randomized traffic, including drops before grant and toggles during SUB
      for (int n = 0; n < 400; n++) begin
         if (req_a && last_gnt_a) begin
            req_a = ($urandom_range(1, 0) == 1);
            word_a = $urandom;
         end else if (req_a) begin
            if ($urandom_range(15, 0) == 0) req_a = 1'b0;
         end else if ($urandom_range(2, 0) == 0) begin
            req_a = 1'b1;
            word_a = $urandom;
         end
         if (req_b && last_gnt_b) begin
            req_b = ($urandom_range(1, 0) == 1);
            word_b = $urandom;
         end else if (req_b) begin
            if ($urandom_range(15, 0) == 0) req_b = 1'b0;
         end else if ($urandom_range(2, 0) == 0) begin
            req_b = 1'b1;
            word_b = $urandom;
         end
         step();
      end

      // lone B held: back-to-back every 5 cycles
      req_a = 1'b0;
      req_b = 1'b1;
      word_b = $urandom;
      repeat (30) begin
         if (last_gnt_b) word_b = $urandom;
         step();
      end

      // reset in cycle G+2 of an A operation
      req_b = 1'b0;
      repeat (8) step();
      req_a = 1'b1;
      word_a = $urandom;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         step();
         got = last_gnt_a;
      end
      check("reset_test_grant_seen", {31'd0, got}, 32'h1);
      req_a = 1'b0;
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1 check_all_zero("async_rst");
      repeat (2) step();
      rst_n = 1'b1;
      repeat (12) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
